instr_encoder: RTL and testbench

- Inverse of the core's RV32I instruction decoder: accepts decoded instruction fields over a valid/ready stream and packs them into 32-bit RV32I instruction words.
- Writes the packed words sequentially into instruction memory through a backpressured write port.
- Used by the boot/program loader and by self-checking benches to build imem images from field-level descriptions.
- Run-based: `start` arms the block at a base address; the run ends on the instruction flagged `in_last`.

---
 rtl/instr_encoder_pkg.sv | 27 ++
 rtl/instr_pack.sv | 107 ++++++++++
 rtl/instr_encoder.sv | 168 ++++++++++++++++
 tb/tb_instr_encoder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - shared opcode constants and FSM state encoding for instr_encoder
//
// Purpose : RV32I major-opcode constants shared with the decoder, plus the
//           run-control FSM state type used by instr_encoder.
// Ports   : none (package)
package instr_encoder_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_ART    = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational RV32I field-to-word packer
//
// Purpose : Packs decoded instruction fields into a 32-bit RV32I word and
//           flags whether the opcode is supported and the immediate fits.
// Config  : IMM_RANGE_CHECK_EN - when defined, o_range_ok reflects the
//           immediate range check for the instruction format; otherwise it
//           is constantly 1 and immediates are truncated to their fields.
// Ports   : i_op, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm - fields
//           o_word      - packed instruction word
//           o_supported - opcode is one of the known RV32I major opcodes
//           o_range_ok  - immediate representable in its field
module instr_pack
   import instr_encoder_pkg::*;
(
   input  logic [6:0]  i_op,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [2:0]  i_funct3,
   input  logic [6:0]  i_funct7,
   input  logic [31:0] i_imm,
   output logic [31:0] o_word,
   output logic        o_supported,
   output logic        o_range_ok
);

`ifdef IMM_RANGE_CHECK_EN
   logic w_ok_i;
   logic w_ok_b;
   logic w_ok_j;
   logic w_ok_u;
   logic w_ok_sh;

   // A signed value fits in N bits when all bits from N-1 upward agree.
   assign w_ok_i  = (i_imm[31:11] == '0) || (i_imm[31:11] == '1);
   assign w_ok_b  = ((i_imm[31:12] == '0) || (i_imm[31:12] == '1)) && !i_imm[0];
   assign w_ok_j  = ((i_imm[31:20] == '0) || (i_imm[31:20] == '1)) && !i_imm[0];
   assign w_ok_u  = (i_imm[11:0] == '0);
   assign w_ok_sh = (i_imm[31:5] == '0);
`endif

   always_comb begin
      o_word      = '0;
      o_supported = 1'b1;
      o_range_ok  = 1'b1;
      case (i_op)
         OP_LUI, OP_AUIPC: begin
            o_word = {i_imm[31:12], i_rd, i_op};
`ifdef IMM_RANGE_CHECK_EN
            o_range_ok = w_ok_u;
`endif
         end
         OP_JAL: begin
            o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_op};
`ifdef IMM_RANGE_CHECK_EN
            o_range_ok = w_ok_j;
`endif
         end
         OP_JALR, OP_LOAD: begin
            o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_op};
`ifdef IMM_RANGE_CHECK_EN
            o_range_ok = w_ok_i;
`endif
         end
         OP_STORE: begin
            o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_op};
`ifdef IMM_RANGE_CHECK_EN
            o_range_ok = w_ok_i;
`endif
         end
         OP_BRANCH: begin
            o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                      i_imm[4:1], i_imm[11], i_op};
`ifdef IMM_RANGE_CHECK_EN
            o_range_ok = w_ok_b;
`endif
         end
         OP_IMM: begin
            // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt.
            if (i_funct3 == 3'b001 || i_funct3 == 3'b101) begin
               o_word = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_op};
`ifdef IMM_RANGE_CHECK_EN
               o_range_ok = w_ok_sh;
`endif
            end else begin
               o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_op};
`ifdef IMM_RANGE_CHECK_EN
               o_range_ok = w_ok_i;
`endif
            end
         end
         OP_ART: begin
            o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_op};
         end
         OP_FENCE, OP_SYSTEM: begin
            o_word = {i_imm[11:0], 5'b0, i_funct3, 5'b0, i_op};
`ifdef IMM_RANGE_CHECK_EN
            o_range_ok = w_ok_i;
`endif
         end
         default: begin
            o_supported = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - run-based RV32I field-bundle encoder writing into imem
//
// Purpose : Accepts decoded instruction field bundles on a valid/ready
//           stream, packs them into RV32I words and writes them sequentially
//           to instruction memory through a backpressured write port.
// Config  : IMM_RANGE_CHECK_EN - drop bundles whose immediate is out of range
//           and report it on imm_err; when undefined imm_err is tied to 0.
// Ports   : clk, rst (async, active high)
//           start, base_addr            - arm a run at a base byte address
//           in_valid/in_ready/in_last   - field bundle handshake
//           opCode, rs1, rs2, rd, funct3, funct7, imm - field bundle
//           mem_we/mem_addr/mem_wdata/mem_ready - imem write port
//           busy, done, word_cnt, op_err, imm_err - run status
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int CNT_W  = 10
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [6:0]        opCode,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [4:0]        rd,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic [31:0]       imm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  word_cnt,
   output logic              op_err,
   output logic              imm_err
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_pend;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_op_err;

   logic [31:0]         w_word;
   logic                w_supported;
   logic                w_range_ok;
   logic                w_slot_free;
   logic                w_accept;
   logic                w_wr_done;
   logic                w_write;
   logic                w_start_run;

   instr_pack u_pack (
      .i_op        (opCode),
      .i_rd        (rd),
      .i_rs1       (rs1),
      .i_rs2       (rs2),
      .i_funct3    (funct3),
      .i_funct7    (funct7),
      .i_imm       (imm),
      .o_word      (w_word),
      .o_supported (w_supported),
      .o_range_ok  (w_range_ok)
   );

   // The output register can take a new word when empty or when its current
   // word retires this cycle, which gives back-to-back writes with no bubble.
   assign w_slot_free = !r_pend || mem_ready;
   assign w_accept    = in_valid && (r_state == ST_RUN) && w_slot_free;
   assign w_wr_done   = r_pend && mem_ready;
   assign w_write     = w_accept && w_supported && w_range_ok;
   assign w_start_run = (r_state == ST_IDLE) && start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            in_ready = w_slot_free;
            if (w_accept && in_last) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!r_pend) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done        = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend   <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_cnt    <= '0;
         r_op_err <= 1'b0;
      end else begin
         if (w_start_run) begin
            r_addr   <= base_addr & ~ADDR_W'(3);
            r_cnt    <= '0;
            r_op_err <= 1'b0;
         end else if (w_wr_done) begin
            r_addr <= r_addr + ADDR_W'(4);
            if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
         end

         if (w_write) begin
            r_pend  <= 1'b1;
            r_wdata <= w_word;
         end else if (w_wr_done) begin
            r_pend <= 1'b0;
         end

         if (w_accept && !w_supported) r_op_err <= 1'b1;
      end
   end

`ifdef IMM_RANGE_CHECK_EN
   logic r_imm_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_imm_err <= 1'b0;
      end else if (w_start_run) begin
         r_imm_err <= 1'b0;
      end else if (w_accept && w_supported && !w_range_ok) begin
         r_imm_err <= 1'b1;
      end
   end

   assign imm_err = r_imm_err;
`else
   assign imm_err = 1'b0;
`endif

   assign mem_we    = r_pend;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign word_cnt  = r_cnt;
   assign op_err    = r_op_err;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder
module tb_instr_encoder;

   localparam int ADDR_W = 12;
   localparam int CNT_W  = 10;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              in_last = 1'b0;
   logic [6:0]        opCode = '0;
   logic [4:0]        rs1 = '0;
   logic [4:0]        rs2 = '0;
   logic [4:0]        rd = '0;
   logic [2:0]        funct3 = '0;
   logic [6:0]        funct7 = '0;
   logic [31:0]       imm = '0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_ready = 1'b1;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  word_cnt;
   logic              op_err;
   logic              imm_err;

   instr_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_last   (in_last),
      .opCode    (opCode),
      .rs1       (rs1),
      .rs2       (rs2),
      .rd        (rd),
      .funct3    (funct3),
      .funct7    (funct7),
      .imm       (imm),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .busy      (busy),
      .done      (done),
      .word_cnt  (word_cnt),
      .op_err    (op_err),
      .imm_err   (imm_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  n_checks   = 0;
   int  n_pass     = 0;
   int  done_total = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Scoreboard: every completed write pops the oldest expected write.
   always @(negedge clk) begin
      if (done) done_total++;
      if (!rst && mem_we && mem_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_wr", 32'(mem_wdata), 32'hDEAD_BEEF);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", 32'(mem_addr), e.addr);
            check("wr_data", mem_wdata, e.data);
         end
      end
   end

   task automatic start_run(input logic [ADDR_W-1:0] b);
      @(posedge clk); #1;
      start = 1'b1;
      base_addr = b;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7,
                       input logic [31:0] im, input logic last);
      int  n;
      logic got;
      n   = 0;
      got = 1'b0;
      opCode = op; rd = d; funct3 = f3; rs1 = s1; rs2 = s2; funct7 = f7; imm = im;
      in_last  = last;
      in_valid = 1'b1;
      while (!got && n < 200) begin
         @(negedge clk);
         if (in_ready) got = 1'b1;
         n++;
      end
      if (!got) check("accept_timeout", 32'(got), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_run(input string tag, input int exp_cnt, input logic exp_op);
      int snap;
      int n;
      snap = done_total;
      n    = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_seen"}, 32'(done), 32'd1);
      repeat (3) @(negedge clk);
      check({tag, "_done_once"}, 32'(done_total - snap), 32'd1);
      check({tag, "_word_cnt"}, 32'(word_cnt), 32'(exp_cnt));
      check({tag, "_op_err"}, 32'(op_err), 32'(exp_op));
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #1;
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_word_cnt", 32'(word_cnt), 32'd0);
      check("rst_op_err", 32'(op_err), 32'd0);
      check("rst_imm_err", 32'(imm_err), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // ADDI / LUI / SW at base 0x100
      start_run(12'h100);
      check("run_busy", 32'(busy), 32'd1);
      expect_wr(32'h100, 32'h0050_0093);
      expect_wr(32'h104, 32'h1234_5137);
      expect_wr(32'h108, 32'h0051_2423);
      send(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd5, 1'b0);
      send(7'h37, 5'd2, 3'd0, 5'd0, 5'd0, 7'h00, 32'h1234_5000, 1'b0);
      send(7'h23, 5'd0, 3'd2, 5'd2, 5'd5, 7'h00, 32'd8, 1'b1);
      wait_run("basic", 3, 1'b0);

      // BEQ / JAL / SRAI
      start_run(12'h000);
      expect_wr(32'h000, 32'hFE20_8EE3);
      expect_wr(32'h004, 32'h0080_00EF);
      expect_wr(32'h008, 32'h4041_D193);
      send(7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'h00, -32'sd4, 1'b0);
      send(7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd8, 1'b0);
      send(7'h13, 5'd3, 3'd5, 5'd3, 5'd0, 7'h20, 32'd4, 1'b1);
      wait_run("bjs", 3, 1'b0);

      // Backpressure: first word stalls for 3+ cycles, start ignored while busy
      start_run(12'h020);
      mem_ready = 1'b0;
      expect_wr(32'h020, 32'h0010_0093);
      expect_wr(32'h024, 32'h0020_0093);
      expect_wr(32'h028, 32'h0030_0093);
      expect_wr(32'h02C, 32'h0040_0093);
      send(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_we", 32'(mem_we), 32'd1);
         check("stall_addr", 32'(mem_addr), 32'h020);
         check("stall_data", mem_wdata, 32'h0010_0093);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         start = (i == 0);
         base_addr = 12'h3C0;
      end
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      mem_ready = 1'b1;
      send(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd2, 1'b0);
      send(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd3, 1'b0);
      send(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd4, 1'b1);
      wait_run("stall", 4, 1'b0);

      // Unsupported opcode then ECALL with last
      start_run(12'h040);
      expect_wr(32'h040, 32'h0000_0073);
      send(7'h7F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd0, 1'b0);
      send(7'h73, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'd0, 1'b1);
      wait_run("operr", 1, 1'b1);

      // Address wrap; low base bits are dropped (0xFFE -> 0xFFC)
      start_run(12'hFFE);
      expect_wr(32'hFFC, 32'h0070_0113);
      expect_wr(32'h000, 32'hFFF0_0193);
      send(7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'h00, 32'd7, 1'b0);
      send(7'h13, 5'd3, 3'd0, 5'd0, 5'd0, 7'h00, -32'sd1, 1'b1);
      wait_run("wrap", 2, 1'b0);

      // ADDI x1,x2,4096: out of I-type range
      start_run(12'h080);
`ifdef IMM_RANGE_CHECK_EN
      send(7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 7'h00, 32'd4096, 1'b1);
      wait_run("immchk", 0, 1'b0);
      check("imm_err", 32'(imm_err), 32'd1);
`else
      expect_wr(32'h080, 32'h0001_0093);
      send(7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 7'h00, 32'd4096, 1'b1);
      wait_run("immtrunc", 1, 1'b0);
      check("imm_err", 32'(imm_err), 32'd0);
`endif

      // Reset during a stalled write discards it
      start_run(12'h200);
      mem_ready = 1'b0;
      send(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd9, 1'b0);
      @(negedge clk);
      check("pre_rst_we", 32'(mem_we), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_we", 32'(mem_we), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_cnt", 32'(word_cnt), 32'd0);
      #2;
      rst = 1'b0;
      mem_ready = 1'b1;
      start_run(12'h300);
      expect_wr(32'h300, 32'h0010_0093);
      send(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd1, 1'b1);
      wait_run("post_rst", 1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
